// File: rtl/reg_file_if.sv
// Register-file bus: two read ports, one write port and the busy-scoreboard
// issue port. The datapath/control side uses master; the register file uses slave.
interface reg_file_if #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned ADDR_W = 5
);

  logic [ADDR_W-1:0] raddr1;
  logic [ADDR_W-1:0] raddr2;
  logic [DATA_W-1:0] rdata1;
  logic [DATA_W-1:0] rdata2;
  logic              busy1;
  logic              busy2;
  logic              we;
  logic [ADDR_W-1:0] waddr;
  logic [DATA_W-1:0] wdata;
  logic              issue;
  logic [ADDR_W-1:0] issue_addr;

  modport master (
    output raddr1, raddr2, we, waddr, wdata, issue, issue_addr,
    input  rdata1, rdata2, busy1, busy2
  );

  modport slave (
    input  raddr1, raddr2, we, waddr, wdata, issue, issue_addr,
    output rdata1, rdata2, busy1, busy2
  );

endinterface

// File: rtl/reg_file.sv
// MIPS register file: 2^ADDR_W x DATA_W registers, two combinational read
// ports, one synchronous write port, and a per-register busy scoreboard used
// by control to stall on read-after-write hazards. Register 0 is hard-wired
// to zero and never busy.
// Optional feature: define REGFILE_BYPASS_EN for write-through bypass of
// same-cycle write data (and busy clear) onto the read ports.
module reg_file #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned ADDR_W = 5
) (
  input  logic       clk,
  input  logic       reset,
  reg_file_if.slave  bus
);

  localparam int unsigned DEPTH = 1 << ADDR_W;

  // Register 0 is not stored; storage and busy bits cover 1..DEPTH-1 only.
  logic [DATA_W-1:0] regs_q [1:DEPTH-1];
  logic [DATA_W-1:0] regs_d [1:DEPTH-1];
  logic [DEPTH-1:1]  busy_q;
  logic [DEPTH-1:1]  busy_d;

  logic wr_valid;
  logic iss_valid;

  assign wr_valid  = bus.we    && (bus.waddr      != '0);
  assign iss_valid = bus.issue && (bus.issue_addr != '0);

  // Next-state: write clears busy, issue sets it; issue wins on the same address.
  always_comb begin
    regs_d = regs_q;
    busy_d = busy_q;
    for (int unsigned i = 1; i < DEPTH; i++) begin
      if (wr_valid && (bus.waddr == ADDR_W'(i))) begin
        regs_d[i] = bus.wdata;
        busy_d[i] = 1'b0;
      end
      if (iss_valid && (bus.issue_addr == ADDR_W'(i))) begin
        busy_d[i] = 1'b1;
      end
    end
  end

  // State register; reset clears everything and discards any same-edge write/issue.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int unsigned i = 1; i < DEPTH; i++) begin
        regs_q[i] <= '0;
      end
      busy_q <= '0;
    end else begin
      regs_q <= regs_d;
      busy_q <= busy_d;
    end
  end

  // Read port 1: stored state, optionally overridden by the in-flight write.
  always_comb begin
    bus.rdata1 = '0;
    bus.busy1  = 1'b0;
    for (int unsigned i = 1; i < DEPTH; i++) begin
      if (bus.raddr1 == ADDR_W'(i)) begin
        bus.rdata1 = regs_q[i];
        bus.busy1  = busy_q[i];
      end
    end
`ifdef REGFILE_BYPASS_EN
    if (wr_valid && (bus.waddr == bus.raddr1)) begin
      bus.rdata1 = bus.wdata;
      bus.busy1  = 1'b0;
    end
`endif
  end

  // Read port 2: same structure as port 1.
  always_comb begin
    bus.rdata2 = '0;
    bus.busy2  = 1'b0;
    for (int unsigned i = 1; i < DEPTH; i++) begin
      if (bus.raddr2 == ADDR_W'(i)) begin
        bus.rdata2 = regs_q[i];
        bus.busy2  = busy_q[i];
      end
    end
`ifdef REGFILE_BYPASS_EN
    if (wr_valid && (bus.waddr == bus.raddr2)) begin
      bus.rdata2 = bus.wdata;
      bus.busy2  = 1'b0;
    end
`endif
  end

endmodule

// File: tb/tb_reg_file.sv
// Self-checking bench for reg_file: directed scenarios plus a randomized run,
// all checked against an array-based reference model of the register file.
module tb_reg_file;

`ifdef REGFILE_BYPASS_EN
  localparam bit BYPASS = 1'b1;
`else
  localparam bit BYPASS = 1'b0;
`endif

  logic clk;
  logic reset;

  reg_file_if #(.DATA_W(32), .ADDR_W(5)) bus ();

  reg_file #(.DATA_W(32), .ADDR_W(5)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: plain arrays indexed by architectural register number.
  logic [31:0] m_regs [32];
  bit          m_busy [32];

  int n_cmp = 0;
  int n_err = 0;

  // Expected read data for an address, given the current inputs.
  function automatic logic [31:0] exp_rd(input logic [4:0] a);
    if (a == 5'd0) return 32'd0;
    if (BYPASS && bus.we && bus.waddr == a) return bus.wdata;
    return m_regs[a];
  endfunction

  // Expected busy flag for an address, given the current inputs.
  function automatic logic exp_busy(input logic [4:0] a);
    if (a == 5'd0) return 1'b0;
    if (BYPASS && bus.we && bus.waddr == a) return 1'b0;
    return m_busy[a];
  endfunction

  // Advance one clock; apply the architectural rules to the model at the edge.
  task automatic tick();
    @(posedge clk);
    if (reset) begin
      for (int i = 0; i < 32; i++) begin
        m_regs[i] = 32'd0;
        m_busy[i] = 1'b0;
      end
    end else begin
      if (bus.we && bus.waddr != 5'd0) begin
        m_regs[bus.waddr] = bus.wdata;
        m_busy[bus.waddr] = 1'b0;
      end
      if (bus.issue && bus.issue_addr != 5'd0) m_busy[bus.issue_addr] = 1'b1;
    end
    #1;
  endtask

  task automatic idle_inputs();
    reset          = 1'b0;
    bus.we         = 1'b0;
    bus.waddr      = 5'd0;
    bus.wdata      = 32'd0;
    bus.issue      = 1'b0;
    bus.issue_addr = 5'd0;
  endtask

  task automatic test_reset();
    idle_inputs();
    bus.raddr1 = 5'd0;
    bus.raddr2 = 5'd0;
    reset = 1'b1;
    tick();
    reset = 1'b0;
    for (int a = 0; a < 32; a++) begin
      bus.raddr1 = 5'(a);
      bus.raddr2 = 5'(31 - a);
      #1;
      n_cmp += 4;
      if (bus.rdata1 !== 32'd0) begin
        n_err++; $display("FAIL reset_rdata1 a=%0d got %h want 0", a, bus.rdata1);
      end
      if (bus.rdata2 !== 32'd0) begin
        n_err++; $display("FAIL reset_rdata2 a=%0d got %h want 0", 31 - a, bus.rdata2);
      end
      if (bus.busy1 !== 1'b0) begin
        n_err++; $display("FAIL reset_busy1 a=%0d got %b want 0", a, bus.busy1);
      end
      if (bus.busy2 !== 1'b0) begin
        n_err++; $display("FAIL reset_busy2 a=%0d got %b want 0", 31 - a, bus.busy2);
      end
    end
    // Writes to register 0 are dropped, in the write cycle and afterwards.
    bus.raddr1 = 5'd0;
    bus.raddr2 = 5'd0;
    bus.we     = 1'b1;
    bus.waddr  = 5'd0;
    bus.wdata  = 32'hDEADBEEF;
    #1;
    n_cmp++;
    if (bus.rdata1 !== 32'd0) begin
      n_err++; $display("FAIL zero_write_same got %h want 0", bus.rdata1);
    end
    tick();
    bus.we = 1'b0;
    #1;
    n_cmp += 2;
    if (bus.rdata1 !== 32'd0) begin
      n_err++; $display("FAIL zero_write_after1 got %h want 0", bus.rdata1);
    end
    if (bus.busy2 !== 1'b0 || bus.rdata2 !== 32'd0) begin
      n_err++; $display("FAIL zero_write_after2 got %h/%b want 0/0", bus.rdata2, bus.busy2);
    end
  endtask

  task automatic test_basic();
    idle_inputs();
    bus.we = 1'b1; bus.waddr = 5'd5;  bus.wdata = 32'h12345678;
    tick();
    bus.waddr = 5'd31; bus.wdata = 32'hFFFFFFFF;
    tick();
    bus.we = 1'b0;
    bus.raddr1 = 5'd5;
    bus.raddr2 = 5'd31;
    #1;
    n_cmp += 2;
    if (bus.rdata1 !== 32'h12345678) begin
      n_err++; $display("FAIL basic_r5 got %h want 12345678", bus.rdata1);
    end
    if (bus.rdata2 !== 32'hFFFFFFFF) begin
      n_err++; $display("FAIL basic_r31 got %h want ffffffff", bus.rdata2);
    end
  endtask

  task automatic test_same_cycle();
    logic [31:0] want_now;
    idle_inputs();
    bus.raddr1 = 5'd7;
    bus.raddr2 = 5'd7;
    bus.we = 1'b1; bus.waddr = 5'd7; bus.wdata = 32'hA5A5A5A5;
    #1;
    want_now = BYPASS ? 32'hA5A5A5A5 : 32'd0;
    n_cmp += 2;
    if (bus.rdata1 !== want_now) begin
      n_err++; $display("FAIL same_cycle_r1 got %h want %h", bus.rdata1, want_now);
    end
    if (bus.rdata2 !== bus.rdata1 || bus.rdata2 !== want_now) begin
      n_err++; $display("FAIL same_cycle_r2 got %h want %h", bus.rdata2, want_now);
    end
    tick();
    bus.we = 1'b0;
    #1;
    n_cmp++;
    if (bus.rdata1 !== 32'hA5A5A5A5) begin
      n_err++; $display("FAIL same_cycle_next got %h want a5a5a5a5", bus.rdata1);
    end
  endtask

  task automatic test_scoreboard();
    logic want_b;
    idle_inputs();
    bus.issue = 1'b1; bus.issue_addr = 5'd9;
    tick();
    bus.issue = 1'b0;
    bus.raddr2 = 5'd9;
    #1;
    n_cmp++;
    if (bus.busy2 !== 1'b1) begin
      n_err++; $display("FAIL sb_busy_set got %b want 1", bus.busy2);
    end
    tick();
    n_cmp++;
    if (bus.busy2 !== 1'b1) begin
      n_err++; $display("FAIL sb_busy_hold got %b want 1", bus.busy2);
    end
    bus.we = 1'b1; bus.waddr = 5'd9; bus.wdata = 32'h55;
    #1;
    want_b = BYPASS ? 1'b0 : 1'b1;
    n_cmp++;
    if (bus.busy2 !== want_b) begin
      n_err++; $display("FAIL sb_busy_write_cycle got %b want %b", bus.busy2, want_b);
    end
    tick();
    bus.we = 1'b0;
    #1;
    n_cmp += 2;
    if (bus.busy2 !== 1'b0) begin
      n_err++; $display("FAIL sb_busy_cleared got %b want 0", bus.busy2);
    end
    if (bus.rdata2 !== 32'h55) begin
      n_err++; $display("FAIL sb_data got %h want 55", bus.rdata2);
    end
  endtask

  task automatic test_issue_write_same();
    idle_inputs();
    bus.issue = 1'b1; bus.issue_addr = 5'd3;
    bus.we = 1'b1; bus.waddr = 5'd3; bus.wdata = 32'h77;
    tick();
    idle_inputs();
    bus.raddr1 = 5'd3;
    #1;
    n_cmp += 2;
    if (bus.rdata1 !== 32'h77) begin
      n_err++; $display("FAIL iw_same_data got %h want 77", bus.rdata1);
    end
    if (bus.busy1 !== 1'b1) begin
      n_err++; $display("FAIL iw_same_busy got %b want 1", bus.busy1);
    end
  endtask

  task automatic test_reset_mid();
    idle_inputs();
    bus.we = 1'b1; bus.waddr = 5'd4; bus.wdata = 32'h44;
    tick();
    bus.waddr = 5'd9; bus.wdata = 32'h1234;
    tick();
    bus.we = 1'b0;
    bus.issue = 1'b1; bus.issue_addr = 5'd9;
    tick();
    bus.issue = 1'b0;
    bus.we = 1'b1; bus.waddr = 5'd4; bus.wdata = 32'h99;
    reset = 1'b1;
    tick();
    idle_inputs();
    bus.raddr1 = 5'd4;
    bus.raddr2 = 5'd9;
    #1;
    n_cmp += 3;
    if (bus.rdata1 !== 32'd0) begin
      n_err++; $display("FAIL rst_mid_r4 got %h want 0", bus.rdata1);
    end
    if (bus.rdata2 !== 32'd0) begin
      n_err++; $display("FAIL rst_mid_r9 got %h want 0", bus.rdata2);
    end
    if (bus.busy2 !== 1'b0) begin
      n_err++; $display("FAIL rst_mid_busy9 got %b want 0", bus.busy2);
    end
  endtask

  // Random traffic with narrow address ranges to provoke collisions.
  task automatic test_random();
    logic [31:0] w1, w2;
    logic        b1, b2;
    for (int c = 0; c < 400; c++) begin
      reset          = ($urandom_range(0, 63) == 0);
      bus.we         = $urandom_range(0, 1) == 1;
      bus.issue      = $urandom_range(0, 2) == 0;
      bus.waddr      = ($urandom_range(0, 1) == 1) ? 5'($urandom_range(0, 7)) : 5'($urandom);
      bus.issue_addr = ($urandom_range(0, 1) == 1) ? 5'($urandom_range(0, 7)) : 5'($urandom);
      bus.raddr1     = ($urandom_range(0, 1) == 1) ? 5'($urandom_range(0, 7)) : 5'($urandom);
      bus.raddr2     = ($urandom_range(0, 3) == 0) ? bus.raddr1 : 5'($urandom_range(0, 7));
      bus.wdata      = $urandom;
      #1;
      w1 = exp_rd(bus.raddr1);
      w2 = exp_rd(bus.raddr2);
      b1 = exp_busy(bus.raddr1);
      b2 = exp_busy(bus.raddr2);
      n_cmp += 4;
      if (bus.rdata1 !== w1) begin
        n_err++; $display("FAIL rnd_rdata1 c=%0d a=%0d got %h want %h", c, bus.raddr1, bus.rdata1, w1);
      end
      if (bus.rdata2 !== w2) begin
        n_err++; $display("FAIL rnd_rdata2 c=%0d a=%0d got %h want %h", c, bus.raddr2, bus.rdata2, w2);
      end
      if (bus.busy1 !== b1) begin
        n_err++; $display("FAIL rnd_busy1 c=%0d a=%0d got %b want %b", c, bus.raddr1, bus.busy1, b1);
      end
      if (bus.busy2 !== b2) begin
        n_err++; $display("FAIL rnd_busy2 c=%0d a=%0d got %b want %b", c, bus.raddr2, bus.busy2, b2);
      end
      tick();
    end
    idle_inputs();
  endtask

  initial begin
    idle_inputs();
    bus.raddr1 = 5'd0;
    bus.raddr2 = 5'd0;
    for (int i = 0; i < 32; i++) begin
      m_regs[i] = 32'd0;
      m_busy[i] = 1'b0;
    end
    @(posedge clk);
    #1;
    test_reset();
    test_basic();
    test_same_cycle();
    test_scoreboard();
    test_issue_write_same();
    test_reset_mid();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
